// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 burst master: one command becomes one INCR burst
// (write: AW -> W -> B, read: AR -> R) with a one-cycle completion pulse.
module axi_burst_master #(
    parameter logic [3:0]  AXI_ID    = 4'h0,
    parameter logic [31:0] ADDR_MASK = 32'h07FF_FFFF
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [7:0]  cmd_len,
    input  logic        wd_valid,
    output logic        wd_ready,
    input  logic [63:0] wd_data,
    input  logic [7:0]  wd_strb,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [63:0] rd_data,
    output logic        rd_last,
    output logic        done,
    output logic        done_err,
    output logic        io_axi4_0_aw_valid,
    input  logic        io_axi4_0_aw_ready,
    output logic [3:0]  io_axi4_0_aw_id,
    output logic [31:0] io_axi4_0_aw_addr,
    output logic [7:0]  io_axi4_0_aw_len,
    output logic [2:0]  io_axi4_0_aw_size,
    output logic [1:0]  io_axi4_0_aw_burst,
    output logic        io_axi4_0_aw_lock,
    output logic [3:0]  io_axi4_0_aw_cache,
    output logic [2:0]  io_axi4_0_aw_prot,
    output logic [3:0]  io_axi4_0_aw_qos,
    output logic        io_axi4_0_w_valid,
    input  logic        io_axi4_0_w_ready,
    output logic [63:0] io_axi4_0_w_data,
    output logic [7:0]  io_axi4_0_w_strb,
    output logic        io_axi4_0_w_last,
    input  logic        io_axi4_0_b_valid,
    output logic        io_axi4_0_b_ready,
    input  logic [3:0]  io_axi4_0_b_id,
    input  logic [1:0]  io_axi4_0_b_resp,
    output logic        io_axi4_0_ar_valid,
    input  logic        io_axi4_0_ar_ready,
    output logic [3:0]  io_axi4_0_ar_id,
    output logic [31:0] io_axi4_0_ar_addr,
    output logic [7:0]  io_axi4_0_ar_len,
    output logic [2:0]  io_axi4_0_ar_size,
    output logic [1:0]  io_axi4_0_ar_burst,
    output logic        io_axi4_0_ar_lock,
    output logic [3:0]  io_axi4_0_ar_cache,
    output logic [2:0]  io_axi4_0_ar_prot,
    output logic [3:0]  io_axi4_0_ar_qos,
    input  logic        io_axi4_0_r_valid,
    output logic        io_axi4_0_r_ready,
    input  logic [3:0]  io_axi4_0_r_id,
    input  logic [63:0] io_axi4_0_r_data,
    input  logic [1:0]  io_axi4_0_r_resp,
    input  logic        io_axi4_0_r_last
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_AW   = 3'd1,
        S_W    = 3'd2,
        S_B    = 3'd3,
        S_AR   = 3'd4,
        S_R    = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        done_q, done_d;
    logic        rdy_en_q, rdy_en_d;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // State, command capture, beat counter, error and completion registers
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            addr_q   <= 32'h0000_0000;
            len_q    <= 8'h00;
            cnt_q    <= 8'h00;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            done_q   <= done_d;
            rdy_en_q <= rdy_en_d;
        end
    end

    // Next-state logic; done_d fires on the final handshake so done lands in the first IDLE cycle
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        done_d   = 1'b0;
        rdy_en_d = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && rdy_en_q) begin
                    addr_d  = cmd_addr & ADDR_MASK;
                    len_d   = cmd_len;
                    cnt_d   = 8'h00;
                    err_d   = 1'b0;
                    state_d = cmd_write ? S_AW : S_AR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_AW: begin
                if (io_axi4_0_aw_ready) state_d = S_W;
                else                    state_d = S_AW;
            end
            S_W: begin
                if (wd_valid && io_axi4_0_w_ready) begin
                    cnt_d   = sat_inc(cnt_q);
                    state_d = (cnt_q == len_q) ? S_B : S_W;
                end else begin
                    state_d = S_W;
                end
            end
            S_B: begin
                if (io_axi4_0_b_valid) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    err_d   = err_q | (io_axi4_0_b_resp != 2'b00) | (io_axi4_0_b_id != AXI_ID);
                end else begin
                    state_d = S_B;
                end
            end
            S_AR: begin
                if (io_axi4_0_ar_ready) state_d = S_R;
                else                    state_d = S_AR;
            end
            S_R: begin
                if (io_axi4_0_r_valid && rd_ready) begin
                    cnt_d = sat_inc(cnt_q);
                    err_d = err_q | (io_axi4_0_r_resp != 2'b00) | (io_axi4_0_r_id != AXI_ID)
                          | (io_axi4_0_r_last && (cnt_q != len_q));
                    if (io_axi4_0_r_last) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_R;
                    end
                end else begin
                    state_d = S_R;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // rdy_en_q keeps cmd_ready low until the first edge after reset release
    assign cmd_ready = (state_q == S_IDLE) && rdy_en_q;
    assign done      = done_q;
    assign done_err  = done_q & err_q;

    assign io_axi4_0_aw_valid = (state_q == S_AW);
    assign io_axi4_0_aw_id    = AXI_ID;
    assign io_axi4_0_aw_addr  = addr_q;
    assign io_axi4_0_aw_len   = len_q;
    assign io_axi4_0_aw_size  = 3'd3;
    assign io_axi4_0_aw_burst = 2'b01;
    assign io_axi4_0_aw_lock  = 1'b0;
    assign io_axi4_0_aw_cache = 4'h3;
    assign io_axi4_0_aw_prot  = 3'h0;
    assign io_axi4_0_aw_qos   = 4'h0;

    assign io_axi4_0_ar_valid = (state_q == S_AR);
    assign io_axi4_0_ar_id    = AXI_ID;
    assign io_axi4_0_ar_addr  = addr_q;
    assign io_axi4_0_ar_len   = len_q;
    assign io_axi4_0_ar_size  = 3'd3;
    assign io_axi4_0_ar_burst = 2'b01;
    assign io_axi4_0_ar_lock  = 1'b0;
    assign io_axi4_0_ar_cache = 4'h3;
    assign io_axi4_0_ar_prot  = 3'h0;
    assign io_axi4_0_ar_qos   = 4'h0;

    assign io_axi4_0_w_valid = (state_q == S_W) && wd_valid;
    assign wd_ready          = (state_q == S_W) && io_axi4_0_w_ready;
    assign io_axi4_0_w_data  = wd_data;
    assign io_axi4_0_w_strb  = wd_strb;
    assign io_axi4_0_w_last  = (cnt_q == len_q);

    assign io_axi4_0_b_ready = (state_q == S_B);

    assign rd_valid          = (state_q == S_R) && io_axi4_0_r_valid;
    assign io_axi4_0_r_ready = (state_q == S_R) && rd_ready;
    assign rd_data           = io_axi4_0_r_data;
    assign rd_last           = io_axi4_0_r_last;

endmodule

// File: tb/tb_axi_burst_master.sv
// Directed bench for axi_burst_master: the bench plays both the command
// source and the AXI slave, with hand-computed expectations per scenario.
module tb_axi_burst_master;

    logic        clock, resetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic        wd_valid, wd_ready;
    logic [63:0] wd_data;
    logic [7:0]  wd_strb;
    logic        rd_valid, rd_ready, rd_last;
    logic [63:0] rd_data;
    logic        done, done_err;
    logic        aw_valid, aw_ready, aw_lock, ar_valid, ar_ready, ar_lock;
    logic [3:0]  aw_id, aw_cache, aw_qos, ar_id, ar_cache, ar_qos;
    logic [31:0] aw_addr, ar_addr;
    logic [7:0]  aw_len, ar_len;
    logic [2:0]  aw_size, aw_prot, ar_size, ar_prot;
    logic [1:0]  aw_burst, ar_burst;
    logic        w_valid, w_ready, w_last;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        b_valid, b_ready;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;
    logic        r_valid, r_ready, r_last;
    logic [3:0]  r_id;
    logic [63:0] r_data;
    logic [1:0]  r_resp;

    int tests_run = 0;
    int fails = 0;

    axi_burst_master dut (
        .clock(clock), .resetn(resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .done_err(done_err),
        .io_axi4_0_aw_valid(aw_valid), .io_axi4_0_aw_ready(aw_ready), .io_axi4_0_aw_id(aw_id),
        .io_axi4_0_aw_addr(aw_addr), .io_axi4_0_aw_len(aw_len), .io_axi4_0_aw_size(aw_size),
        .io_axi4_0_aw_burst(aw_burst), .io_axi4_0_aw_lock(aw_lock), .io_axi4_0_aw_cache(aw_cache),
        .io_axi4_0_aw_prot(aw_prot), .io_axi4_0_aw_qos(aw_qos),
        .io_axi4_0_w_valid(w_valid), .io_axi4_0_w_ready(w_ready), .io_axi4_0_w_data(w_data),
        .io_axi4_0_w_strb(w_strb), .io_axi4_0_w_last(w_last),
        .io_axi4_0_b_valid(b_valid), .io_axi4_0_b_ready(b_ready), .io_axi4_0_b_id(b_id),
        .io_axi4_0_b_resp(b_resp),
        .io_axi4_0_ar_valid(ar_valid), .io_axi4_0_ar_ready(ar_ready), .io_axi4_0_ar_id(ar_id),
        .io_axi4_0_ar_addr(ar_addr), .io_axi4_0_ar_len(ar_len), .io_axi4_0_ar_size(ar_size),
        .io_axi4_0_ar_burst(ar_burst), .io_axi4_0_ar_lock(ar_lock), .io_axi4_0_ar_cache(ar_cache),
        .io_axi4_0_ar_prot(ar_prot), .io_axi4_0_ar_qos(ar_qos),
        .io_axi4_0_r_valid(r_valid), .io_axi4_0_r_ready(r_ready), .io_axi4_0_r_id(r_id),
        .io_axi4_0_r_data(r_data), .io_axi4_0_r_resp(r_resp), .io_axi4_0_r_last(r_last)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Present a command and hold it until the DUT accepts it.
    task automatic accept_cmd(input logic wr, input logic [31:0] addr, input logic [7:0] len);
        int n = 0;
        @(negedge clock);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
        #1;
        while (!cmd_ready && n < 20) begin @(negedge clock); #1; n++; end
        tests_run++;
        if (n >= 20) begin fails++; $display("FAIL cmd_accept_timeout: cmd_ready=%b expected 1", cmd_ready); end
        @(posedge clock); #1;
        cmd_valid = 1'b0;
    endtask

    // Slave side of AW/AR: stall one cycle, then check stable fields and take the address.
    task automatic addr_phase(input logic wr, input logic [31:0] exp_addr, input logic [7:0] exp_len);
        int n = 0;
        logic v; logic [31:0] a; logic [7:0] l; logic [2:0] sz, pr; logic [1:0] bu;
        logic lk; logic [3:0] ca, qo, id;
        @(negedge clock); #1;
        while (!(wr ? aw_valid : ar_valid) && n < 20) begin @(negedge clock); #1; n++; end
        tests_run++;
        if (n >= 20) begin fails++; $display("FAIL addr_valid_timeout: valid=0 expected 1"); end
        tests_run++;
        if (cmd_ready !== 1'b0) begin fails++; $display("FAIL cmd_ready_busy: got %b expected 0", cmd_ready); end
        @(negedge clock); #1;
        v  = wr ? aw_valid : ar_valid;   a  = wr ? aw_addr : ar_addr;
        l  = wr ? aw_len : ar_len;       sz = wr ? aw_size : ar_size;
        bu = wr ? aw_burst : ar_burst;   lk = wr ? aw_lock : ar_lock;
        ca = wr ? aw_cache : ar_cache;   pr = wr ? aw_prot : ar_prot;
        qo = wr ? aw_qos : ar_qos;       id = wr ? aw_id : ar_id;
        tests_run++;
        if (v !== 1'b1) begin fails++; $display("FAIL addr_valid_held: got %b expected 1", v); end
        tests_run++;
        if (a !== exp_addr) begin fails++; $display("FAIL addr_value: got %h expected %h", a, exp_addr); end
        tests_run++;
        if (l !== exp_len) begin fails++; $display("FAIL addr_len: got %0d expected %0d", l, exp_len); end
        tests_run++;
        if ({sz, bu, lk, ca, pr, qo, id} !== {3'd3, 2'b01, 1'b0, 4'h3, 3'h0, 4'h0, 4'h0}) begin
            fails++;
            $display("FAIL addr_attrs: got size=%0d burst=%0d lock=%b cache=%h prot=%h qos=%h id=%h expected 3 1 0 3 0 0 0",
                     sz, bu, lk, ca, pr, qo, id);
        end
        if (wr) aw_ready = 1'b1; else ar_ready = 1'b1;
        @(posedge clock); #1;
        aw_ready = 1'b0; ar_ready = 1'b0;
        tests_run++;
        if ((wr ? aw_valid : ar_valid) !== 1'b0) begin fails++; $display("FAIL addr_valid_drop: got 1 expected 0"); end
    endtask

    // Push nbeats of write data with w_ready high; w_last expected only on beat index len.
    task automatic write_beats(input logic [7:0] len, input int nbeats);
        logic [63:0] exp_d;
        logic [7:0]  exp_s;
        for (int b = 0; b < nbeats; b++) begin
            @(negedge clock);
            exp_d = 64'hD000_0000_0000_0000 | 64'(b);
            exp_s = 8'hFF ^ 8'(b);
            wd_valid = 1'b1; wd_data = exp_d; wd_strb = exp_s; w_ready = 1'b1;
            #1;
            tests_run++;
            if ({w_valid, wd_ready} !== 2'b11) begin fails++; $display("FAIL w_handshake beat%0d: got %b%b expected 11", b, w_valid, wd_ready); end
            tests_run++;
            if (w_data !== exp_d || w_strb !== exp_s) begin fails++; $display("FAIL w_payload beat%0d: got %h/%h expected %h/%h", b, w_data, w_strb, exp_d, exp_s); end
            tests_run++;
            if (w_last !== (b == int'(len))) begin fails++; $display("FAIL w_last beat%0d: got %b expected %b", b, w_last, (b == int'(len))); end
            @(posedge clock); #1;
        end
        wd_valid = 1'b0; w_ready = 1'b0;
    endtask

    // Slave returns a write response.
    task automatic b_phase(input logic [1:0] resp, input logic [3:0] id);
        @(negedge clock);
        b_valid = 1'b1; b_resp = resp; b_id = id;
        #1;
        tests_run++;
        if (b_ready !== 1'b1) begin fails++; $display("FAIL b_ready: got %b expected 1", b_ready); end
        @(posedge clock); #1;
        b_valid = 1'b0; b_resp = 2'b00; b_id = 4'h0;
    endtask

    // Slave streams beats 0..last_idx (r_last on last_idx); a beat advances only on handshake.
    task automatic read_beats(input int last_idx, input logic toggle, output int delivered, output int cycles);
        int beat = 0;
        logic ph = 1'b1;
        logic [63:0] exp_d;
        delivered = 0; cycles = 0;
        while (beat <= last_idx && cycles < 60) begin
            @(negedge clock);
            rd_ready = toggle ? ph : 1'b1;
            ph = ~ph;
            exp_d = 64'hBEEF_0000_0000_0000 | 64'(beat);
            r_valid = 1'b1; r_data = exp_d; r_last = (beat == last_idx); r_resp = 2'b00; r_id = 4'h0;
            #1;
            tests_run++;
            if ({rd_valid, r_ready} !== {1'b1, rd_ready}) begin fails++; $display("FAIL r_flow beat%0d: got rd_valid=%b r_ready=%b expected 1 %b", beat, rd_valid, r_ready, rd_ready); end
            tests_run++;
            if (rd_data !== exp_d || rd_last !== (beat == last_idx)) begin fails++; $display("FAIL r_payload beat%0d: got %h last=%b expected %h last=%b", beat, rd_data, rd_last, exp_d, (beat == last_idx)); end
            @(posedge clock); #1;
            if (rd_ready) begin beat++; delivered++; end
            cycles++;
        end
        r_valid = 1'b0; r_last = 1'b0; rd_ready = 1'b0;
        tests_run++;
        if (cycles >= 60) begin fails++; $display("FAIL r_timeout: got %0d beats expected %0d", beat, last_idx + 1); end
    endtask

    // Completion pulse: high exactly one cycle with the given error flag.
    task automatic check_done(input logic exp_err);
        @(negedge clock); #1;
        tests_run++;
        if ({done, done_err, cmd_ready} !== {1'b1, exp_err, 1'b1}) begin fails++; $display("FAIL done_pulse: got done=%b err=%b rdy=%b expected 1 %b 1", done, done_err, cmd_ready, exp_err); end
        @(negedge clock); #1;
        tests_run++;
        if ({done, done_err} !== 2'b00) begin fails++; $display("FAIL done_width: got done=%b err=%b expected 0 0", done, done_err); end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        tests_run++;
        if ({cmd_ready, done, done_err, aw_valid, ar_valid, w_valid, wd_ready, b_ready, r_ready, rd_valid} !== 10'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b expected 0000000000",
                     {cmd_ready, done, done_err, aw_valid, ar_valid, w_valid, wd_ready, b_ready, r_ready, rd_valid});
        end
        @(negedge clock);
        resetn = 1'b1;
        #1;
        tests_run++;
        if (cmd_ready !== 1'b0) begin fails++; $display("FAIL reset_release_ready: got %b expected 0", cmd_ready); end
        @(posedge clock); #1;
        tests_run++;
        if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_first_edge_ready: got %b expected 1", cmd_ready); end
    endtask

    task automatic test_write_burst();
        accept_cmd(1'b1, 32'h8000_1000, 8'd3);
        addr_phase(1'b1, 32'h0000_1000, 8'd3);
        write_beats(8'd3, 4);
        b_phase(2'b00, 4'h0);
        check_done(1'b0);
    endtask

    task automatic test_write_single_bad_id();
        accept_cmd(1'b1, 32'hFFFF_FFF8, 8'd0);
        addr_phase(1'b1, 32'h07FF_FFF8, 8'd0);
        write_beats(8'd0, 1);
        b_phase(2'b00, 4'h5);
        check_done(1'b1);
    endtask

    task automatic test_read_single();
        int dl, cy;
        accept_cmd(1'b0, 32'h0000_0040, 8'd0);
        addr_phase(1'b0, 32'h0000_0040, 8'd0);
        read_beats(0, 1'b0, dl, cy);
        tests_run++;
        if (dl !== 1) begin fails++; $display("FAIL read_single_count: got %0d expected 1", dl); end
        check_done(1'b0);
    endtask

    task automatic test_read_toggle();
        int dl, cy;
        accept_cmd(1'b0, 32'h0000_2000, 8'd7);
        addr_phase(1'b0, 32'h0000_2000, 8'd7);
        read_beats(7, 1'b1, dl, cy);
        tests_run++;
        if (dl !== 8 || cy !== 15) begin fails++; $display("FAIL read_toggle_count: got %0d beats in %0d cycles expected 8 in 15", dl, cy); end
        check_done(1'b0);
    endtask

    task automatic test_back_to_back();
        int dl, cy;
        accept_cmd(1'b1, 32'h0000_3000, 8'd1);
        addr_phase(1'b1, 32'h0000_3000, 8'd1);
        write_beats(8'd1, 2);
        b_phase(2'b10, 4'h0);
        @(negedge clock);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0100; cmd_len = 8'd0;
        #1;
        tests_run++;
        if ({done, done_err, cmd_ready} !== 3'b111) begin fails++; $display("FAIL b2b_done_cycle: got done=%b err=%b rdy=%b expected 1 1 1", done, done_err, cmd_ready); end
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        tests_run++;
        if ({done, ar_valid} !== 2'b01) begin fails++; $display("FAIL b2b_accepted: got done=%b ar_valid=%b expected 0 1", done, ar_valid); end
        addr_phase(1'b0, 32'h0000_0100, 8'd0);
        read_beats(0, 1'b0, dl, cy);
        check_done(1'b0);
    endtask

    task automatic test_early_last();
        int dl, cy;
        accept_cmd(1'b0, 32'h0000_4000, 8'd3);
        addr_phase(1'b0, 32'h0000_4000, 8'd3);
        read_beats(1, 1'b0, dl, cy);
        tests_run++;
        if (dl !== 2) begin fails++; $display("FAIL early_last_count: got %0d expected 2", dl); end
        check_done(1'b1);
    endtask

    task automatic test_reset_mid_w();
        int dl, cy;
        accept_cmd(1'b1, 32'h0000_5000, 8'd3);
        addr_phase(1'b1, 32'h0000_5000, 8'd3);
        write_beats(8'd3, 2);
        @(negedge clock);
        wd_valid = 1'b1; w_ready = 1'b1;
        #1;
        tests_run++;
        if (w_valid !== 1'b1) begin fails++; $display("FAIL midw_pre: got w_valid=%b expected 1", w_valid); end
        resetn = 1'b0;
        #1;
        tests_run++;
        if ({w_valid, wd_ready, aw_valid, b_ready, cmd_ready} !== 5'b0) begin fails++; $display("FAIL midw_reset_outputs: got %b expected 00000", {w_valid, wd_ready, aw_valid, b_ready, cmd_ready}); end
        @(negedge clock);
        wd_valid = 1'b0; w_ready = 1'b0; resetn = 1'b1;
        @(posedge clock); #1;
        tests_run++;
        if ({cmd_ready, done} !== 2'b10) begin fails++; $display("FAIL midw_release: got rdy=%b done=%b expected 1 0", cmd_ready, done); end
        accept_cmd(1'b0, 32'h0000_6000, 8'd0);
        addr_phase(1'b0, 32'h0000_6000, 8'd0);
        read_beats(0, 1'b0, dl, cy);
        check_done(1'b0);
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_len = 8'h0;
        wd_valid = 1'b0; wd_data = 64'h0; wd_strb = 8'h0; rd_ready = 1'b0;
        aw_ready = 1'b0; ar_ready = 1'b0; w_ready = 1'b0;
        b_valid = 1'b0; b_id = 4'h0; b_resp = 2'b00;
        r_valid = 1'b0; r_id = 4'h0; r_data = 64'h0; r_resp = 2'b00; r_last = 1'b0;
        resetn = 1'b0;
        test_reset();
        test_write_burst();
        test_write_single_bad_id();
        test_read_single();
        test_read_toggle();
        test_back_to_back();
        test_early_last();
        test_reset_mid_w();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
